fir_pair_serializer: RTL

- Output-side companion of the 2-parallel FIR: accepts one output pair per valid cycle, {y[2k], y[2k+1]}, and emits one sample per cycle in time order.
- Buffers pairs in an internal FIFO. Provides a valid/ready handshake to the downstream single-rate consumer.
- Flags, and does not silently corrupt, pairs lost to overflow, because the FIR upstream has no backpressure.

---
 rtl/fir_pair_serializer.sv | 91 +++++++++
 1 files changed

// File: rtl/fir_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fir_pair_serializer
// Description : Buffers {y[2k], y[2k+1]} pairs from a 2-parallel FIR and
//               emits them one sample per transfer, in time order.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_pair_serializer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              ValidIn,
    input  logic [DATA_W-1:0] DataIn1,
    input  logic [DATA_W-1:0] DataIn2,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_lvl_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic                r_phase;
    logic                r_overflow;

    logic                w_transfer;
    logic                w_retire;
    logic                w_push;
    logic [2*DATA_W-1:0] w_head;

    assign w_transfer = out_valid && out_ready;
    assign w_retire   = w_transfer && r_phase;
    // A full FIFO still takes a pair in the cycle its head pair is retired.
    assign w_push     = ValidIn && ((r_level < c_depth) || w_retire);
    assign w_head     = r_mem[r_rd_ptr];

    assign in_ready  = (r_level < c_depth) || w_retire;
    assign out_valid = (r_level != '0);
    assign out_data  = !out_valid ? '0
                     : (r_phase ? w_head[DATA_W-1:0] : w_head[2*DATA_W-1:DATA_W]);
    assign level     = r_level;
    assign overflow  = r_overflow;

    // Storage carries no reset; stale entries are never visible past level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {DataIn1, DataIn2};
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_phase    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_transfer) begin
                r_phase <= ~r_phase;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_retire})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
            if (ValidIn && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
